// File: rtl/win_readout.sv
// Capture-window reader: walks the circular sample RAM from the window start
// and returns one sample per accepted host read strobe.
module win_readout #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic              Start_Read,
   input  logic              Write_Ready,
   input  logic [ADDR_W-1:0] WR_PTR,
   input  logic [ADDR_W:0]   WIN_LEN,
   input  logic              RD_STB,
   input  logic [DATA_W-1:0] MEM_Q,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_RD,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic              DATA_VALID,
   output logic              Read_Done,
   output logic              BUSY
);

   typedef enum logic [2:0] {StIdle, StArmed, StFetch, StCapt, StDone} state_e;

   localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                data_valid_q, data_valid_d;
   logic [ADDR_W:0]     win_clamp;

   // A full-buffer window has zero low bits, so the start lands on WR_PTR.
   assign win_clamp = (WIN_LEN > DepthLen) ? DepthLen : WIN_LEN;

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      remaining_d  = remaining_q;
      mem_addr_d   = mem_addr_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;

      if (!Start_Read) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Write_Ready) begin
                  rd_ptr_d    = WR_PTR - win_clamp[ADDR_W-1:0];
                  remaining_d = win_clamp;
                  state_d     = (win_clamp == '0) ? StDone : StArmed;
               end
            end
            StArmed: begin
               if (RD_STB) begin
                  mem_addr_d = rd_ptr_q;
                  state_d    = StFetch;
               end
            end
            StFetch: begin
               state_d = StCapt;
            end
            StCapt: begin
               data_out_d   = MEM_Q;
               data_valid_d = 1'b1;
               rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
               remaining_d  = remaining_q - (ADDR_W + 1)'(1);
               state_d      = (remaining_q == (ADDR_W + 1)'(1)) ? StDone : StArmed;
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q      <= StIdle;
         rd_ptr_q     <= '0;
         remaining_q  <= '0;
         mem_addr_q   <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         remaining_q  <= remaining_d;
         mem_addr_q   <= mem_addr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign MEM_ADDR   = mem_addr_q;
   assign MEM_RD     = (state_q == StFetch);
   assign DATA_OUT   = data_out_q;
   assign DATA_VALID = data_valid_q;
   assign Read_Done  = (state_q == StDone);
   assign BUSY       = (state_q == StArmed) || (state_q == StFetch) || (state_q == StCapt);

endmodule
